// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, hold buffer and pending redirect
// Optional macro BRANCH_DELAY_SLOT_EN keeps the word fetched alongside a redirect instead of discarding it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_in,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic DELAY_SLOT = 1'b1;
`else
  localparam logic DELAY_SLOT = 1'b0;
`endif

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state;
  logic        pend;
  logic [31:0] pend_tgt;
  logic [31:0] hold_word;
  logic [31:0] next_pc;
  logic        keep_word;

  // A pending target outranks a fresh redirect; it was the older request.
  assign next_pc   = pend ? pend_tgt : (redirect ? npc_in : if_pc + 32'd4);
  assign keep_word = !(pend || redirect) || DELAY_SLOT;
  assign imem_addr = if_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      imem_req  <= 1'b0;
      if_pc     <= RESET_PC;
      id_pc     <= 32'h0;
      id_instr  <= 32'h0;
      id_valid  <= 1'b0;
      pend      <= 1'b0;
      pend_tgt  <= 32'h0;
      hold_word <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (!stall) begin
            if (imem_ack) begin
              if_pc <= next_pc;
              pend  <= 1'b0;
              if (keep_word) begin
                id_pc    <= if_pc;
                id_instr <= imem_rdata;
                id_valid <= 1'b1;
              end else begin
                id_instr <= 32'h0;
                id_valid <= 1'b0;
              end
            end else begin
              id_instr <= 32'h0;
              id_valid <= 1'b0;
              if (redirect) begin
                pend     <= 1'b1;
                pend_tgt <= npc_in;
              end
            end
          end else if (imem_ack) begin
            hold_word <= imem_rdata;
            state     <= HOLD;
            imem_req  <= 1'b0;
          end
        end
        HOLD: begin
          // The held word's successor is decided at release, when redirect is re-presented.
          if (!stall) begin
            if_pc    <= next_pc;
            pend     <= 1'b0;
            state    <= FETCH;
            imem_req <= 1'b1;
            if (keep_word) begin
              id_pc    <= if_pc;
              id_instr <= hold_word;
              id_valid <= 1'b1;
            end else begin
              id_instr <= 32'h0;
              id_valid <= 1'b0;
            end
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit (default build, delay slot off)
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc_in = 32'h0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb[$];

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .npc_in     (npc_in),
    .redirect   (redirect),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_valid   (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    mem = (a == 32'h0000_3004) ? 32'h2108_0001 : {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; stall = 1'b1; redirect = 1'b1; npc_in = 32'h0000_5000;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("rst_if_pc", if_pc, 32'h0000_3000);
    chk("rst_imem_addr", imem_addr, 32'h0000_3000);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
  endtask

  // One clock: drive inputs, optionally push the expected IF/ID pc, then check the load.
  task automatic step(input logic a, input logic s, input logic r, input logic [31:0] n,
                      input logic p, input logic [31:0] pa);
    logic [31:0] exp_pc;
    @(negedge clk);
    rst = 1'b0; imem_ack = a; stall = s; redirect = r; npc_in = n;
    imem_rdata = mem(imem_addr);
    if (p) sb.push_back(pa);
    @(posedge clk); #1;
    if (p) begin
      exp_pc = sb.pop_front();
      chk("word_valid", 32'(id_valid), 32'd1);
      chk("word_pc", id_pc, exp_pc);
      chk("word_instr", id_instr, mem(exp_pc));
    end else if (!s) begin
      chk("bubble_valid", 32'(id_valid), 32'd0);
      chk("bubble_instr", id_instr, 32'h0);
    end
  endtask

  initial begin
    reset_cycle();
    reset_cycle();

    // BOOT: ack ignored, fetch begins at reset pc
    step(1, 0, 0, 32'h0, 0, 32'h0);
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_pc", if_pc, 32'h0000_3000);
    step(1, 0, 0, 32'h0, 1, 32'h0000_3000);
    chk("seq_pc1", if_pc, 32'h0000_3004);

    // stall with ack at 0x3004 -> HOLD, IF/ID frozen
    step(1, 1, 0, 32'h0, 0, 32'h0);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_id_pc", id_pc, 32'h0000_3000);
    step(1, 1, 0, 32'h0, 0, 32'h0);
    chk("hold2_id_instr", id_instr, mem(32'h0000_3000));
    chk("hold2_if_pc", if_pc, 32'h0000_3004);
    step(0, 0, 0, 32'h0, 1, 32'h0000_3004);
    chk("release_pc", if_pc, 32'h0000_3008);
    chk("release_req", 32'(imem_req), 32'd1);

    // redirect with ack at 0x3008 -> wrong-path word dropped
    step(1, 0, 1, 32'h0000_3040, 0, 32'h0);
    chk("redir_pc", if_pc, 32'h0000_3040);
    step(1, 0, 0, 32'h0, 1, 32'h0000_3040);
    chk("after_redir_pc", if_pc, 32'h0000_3044);

    // no ack -> bubble, id_pc kept
    step(0, 0, 0, 32'h0, 0, 32'h0);
    chk("noack_id_pc", id_pc, 32'h0000_3040);
    chk("noack_if_pc", if_pc, 32'h0000_3044);

    // redirect while ack withheld -> pending target
    step(0, 0, 1, 32'h0000_3100, 0, 32'h0);
    chk("pend_addr0", imem_addr, 32'h0000_3044);
    step(0, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 32'h0);
    chk("pend_addr2", imem_addr, 32'h0000_3044);
    step(1, 0, 0, 32'h0, 0, 32'h0);
    chk("pend_taken", if_pc, 32'h0000_3100);
    step(1, 0, 0, 32'h0, 1, 32'h0000_3100);
    chk("pend_cleared", if_pc, 32'h0000_3104);

    // second redirect while pending overwrites the target
    step(0, 0, 1, 32'h0000_3200, 0, 32'h0);
    step(0, 0, 1, 32'h0000_3300, 0, 32'h0);
    step(1, 0, 0, 32'h0, 0, 32'h0);
    chk("overwrite_pc", if_pc, 32'h0000_3300);

    // redirect under stall is ignored
    step(0, 1, 1, 32'h0000_3500, 0, 32'h0);
    chk("stall_redir_pc", if_pc, 32'h0000_3300);
    step(1, 0, 0, 32'h0, 1, 32'h0000_3300);
    chk("stall_redir_seq", if_pc, 32'h0000_3304);

    // wrap from 0xFFFF_FFFC to 0
    step(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    chk("wrap_target", if_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    chk("wrap_zero", if_pc, 32'h0);

    // redirect on HOLD release drops the held word
    step(1, 1, 0, 32'h0, 0, 32'h0);
    step(0, 0, 1, 32'h0000_3600, 0, 32'h0);
    chk("hold_redir_pc", if_pc, 32'h0000_3600);
    chk("hold_redir_req", 32'(imem_req), 32'd1);

    // reset during HOLD
    step(1, 1, 0, 32'h0, 0, 32'h0);
    chk("hold_again_req", 32'(imem_req), 32'd0);
    reset_cycle();
    step(1, 0, 0, 32'h0, 0, 32'h0);
    chk("reboot_pc", if_pc, 32'h0000_3000);
    chk("reboot_req", 32'(imem_req), 32'd1);
    step(1, 0, 0, 32'h0, 1, 32'h0000_3000);
    chk("reboot_seq", if_pc, 32'h0000_3004);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
